// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing. It provides a pixel divider, h/v counters, registered
// blanking flags and sync outputs delayed by a pixel-stepped shift register.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned PIX_DIV    = 2,
  parameter int unsigned SYNC_DELAY = 1
) (
  input  logic       clk_vga,
  input  logic       reset,
  output logic [9:0] CurrentX,
  output logic [8:0] CurrentY,
  output logic       HBlank,
  output logic       VBlank,
  output logic       HSync,
  output logic       VSync,
  output logic       PixelTick,
  output logic       FrameStart
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // One spare divider code so an out-of-range value is always representable and recoverable.
  localparam int unsigned DIV_W   = $clog2(PIX_DIV + 1);
  localparam int unsigned PIPE_W  = SYNC_DELAY + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [8:0]       Y_CLAMP  = 9'(V_ACTIVE - 1);

  logic [DIV_W-1:0]  div_q, div_d;
  logic [9:0]        hcnt_q, hcnt_d;
  logic [9:0]        vcnt_q, vcnt_d;
  logic [9:0]        x_q, x_d;
  logic [8:0]        y_q, y_d;
  logic              hb_q, hb_d;
  logic              vb_q, vb_d;
  logic              pt_q, pt_d;
  logic              fs_q, fs_d;
  logic [PIPE_W-1:0] hs_pipe_q, hs_pipe_d;
  logic [PIPE_W-1:0] vs_pipe_q, vs_pipe_d;
  logic              step, hwrap, hs_raw, vs_raw;

  always_comb begin
    step   = (div_q == DIV_LAST);
    div_d  = (step || div_q > DIV_LAST) ? '0 : div_q + DIV_W'(1);
    hwrap  = step && (hcnt_q == H_LAST);
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (step) begin
      hcnt_d = (hcnt_q >= H_LAST) ? '0 : hcnt_q + 10'd1;
      if (vcnt_q > V_LAST) begin
        vcnt_d = '0;
      end else if (hwrap) begin
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
      end
    end

    // Outputs are derived from the next counter state so they land on the same edge.
    x_d    = hcnt_d;
    y_d    = (32'(vcnt_d) < V_ACTIVE) ? vcnt_d[8:0] : Y_CLAMP;
    hb_d   = (32'(hcnt_d) >= H_ACTIVE);
    vb_d   = (32'(vcnt_d) >= V_ACTIVE);
    pt_d   = step;
    fs_d   = hwrap && (vcnt_q == V_LAST);
    hs_raw = !((32'(hcnt_d) >= H_ACTIVE + H_FP) &&
               (32'(hcnt_d) <  H_ACTIVE + H_FP + H_SYNC));
    vs_raw = !((32'(vcnt_d) >= V_ACTIVE + V_FP) &&
               (32'(vcnt_d) <  V_ACTIVE + V_FP + V_SYNC));

    // Stage 0 is coincident with CurrentX; stage SYNC_DELAY drives the pins.
    hs_pipe_d = hs_pipe_q;
    vs_pipe_d = vs_pipe_q;
    if (step) begin
      hs_pipe_d = PIPE_W'({hs_pipe_q, hs_raw});
      vs_pipe_d = PIPE_W'({vs_pipe_q, vs_raw});
    end
  end

  always_ff @(posedge clk_vga or posedge reset) begin
    if (reset) begin
      div_q     <= '0;
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      hb_q      <= 1'b0;
      vb_q      <= 1'b0;
      pt_q      <= 1'b0;
      fs_q      <= 1'b0;
      hs_pipe_q <= '1;
      vs_pipe_q <= '1;
    end else begin
      div_q     <= div_d;
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      hb_q      <= hb_d;
      vb_q      <= vb_d;
      pt_q      <= pt_d;
      fs_q      <= fs_d;
      hs_pipe_q <= hs_pipe_d;
      vs_pipe_q <= vs_pipe_d;
    end
  end

  assign CurrentX   = x_q;
  assign CurrentY   = y_q;
  assign HBlank     = hb_q;
  assign VBlank     = vb_q;
  assign PixelTick  = pt_q;
  assign FrameStart = fs_q;
  assign HSync      = hs_pipe_q[SYNC_DELAY];
  assign VSync      = vs_pipe_q[SYNC_DELAY];

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: five vga_timing_gen instances (full and reduced geometries, several
// divider/delay settings) checked every cycle against an arithmetic raster model.
module tb_vga_timing_gen;

  localparam int NI = 5;
  // 0: full 2/1   1: small 2/1   2: small 1/0   3: full 1/0   4: small 3/4
  localparam int unsigned HA [NI] = '{640, 16, 16, 640, 16};
  localparam int unsigned HF [NI] = '{16,  2,  2,  16,  2};
  localparam int unsigned HS [NI] = '{96,  4,  4,  96,  4};
  localparam int unsigned HB [NI] = '{48,  3,  3,  48,  3};
  localparam int unsigned VA [NI] = '{480, 8,  8,  480, 8};
  localparam int unsigned VF [NI] = '{10,  2,  2,  10,  2};
  localparam int unsigned VS [NI] = '{2,   2,  2,  2,   2};
  localparam int unsigned VB [NI] = '{33,  3,  3,  33,  3};
  localparam int unsigned PD [NI] = '{2,   2,  1,  1,   3};
  localparam int unsigned SD [NI] = '{1,   1,  0,  0,   4};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] cx [NI];
  logic [8:0] cy [NI];
  logic       hb [NI];
  logic       vb [NI];
  logic       hs [NI];
  logic       vs [NI];
  logic       pt [NI];
  logic       fs [NI];

  int unsigned n = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    vga_timing_gen #(
      .H_ACTIVE(HA[k]), .H_FP(HF[k]), .H_SYNC(HS[k]), .H_BP(HB[k]),
      .V_ACTIVE(VA[k]), .V_FP(VF[k]), .V_SYNC(VS[k]), .V_BP(VB[k]),
      .PIX_DIV(PD[k]), .SYNC_DELAY(SD[k])
    ) u_dut (
      .clk_vga   (clk),
      .reset     (rst),
      .CurrentX  (cx[k]),
      .CurrentY  (cy[k]),
      .HBlank    (hb[k]),
      .VBlank    (vb[k]),
      .HSync     (hs[k]),
      .VSync     (vs[k]),
      .PixelTick (pt[k]),
      .FrameStart(fs[k])
    );
  end

  // Edges seen since reset was last released.
  always @(posedge clk or posedge rst) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  typedef struct {
    int x, y, hb, vb, hs, vs, pt, fs;
  } exp_t;

  function automatic exp_t model(int k, int unsigned cyc);
    exp_t e;
    int unsigned ht = HA[k] + HF[k] + HS[k] + HB[k];
    int unsigned vt = VA[k] + VF[k] + VS[k] + VB[k];
    int unsigned p  = cyc / PD[k];
    int unsigned h  = p % ht;
    int unsigned v  = (p / ht) % vt;
    int unsigned q, hq, vq;
    e.x  = int'(h);
    e.y  = (v < VA[k]) ? int'(v) : int'(VA[k] - 1);
    e.hb = (h >= HA[k]) ? 1 : 0;
    e.vb = (v >= VA[k]) ? 1 : 0;
    e.pt = (cyc >= 1 && cyc % PD[k] == 0) ? 1 : 0;
    e.fs = (e.pt == 1 && p > 0 && p % (ht * vt) == 0) ? 1 : 0;
    if (p < SD[k]) begin
      e.hs = 1;
      e.vs = 1;
    end else begin
      q  = p - SD[k];
      hq = q % ht;
      vq = (q / ht) % vt;
      e.hs = (hq >= HA[k] + HF[k] && hq < HA[k] + HF[k] + HS[k]) ? 0 : 1;
      e.vs = (vq >= VA[k] + VF[k] && vq < VA[k] + VF[k] + VS[k]) ? 0 : 1;
    end
    return e;
  endfunction

  task automatic chk(string nm, int k, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s dut%0d n=%0d: got %0d, expected %0d", nm, k, n, act, expv);
    end
  endtask

  always @(negedge clk) begin : compare
    exp_t e;
    for (int k = 0; k < NI; k++) begin
      e = model(k, n);
      chk("CurrentX",   k, int'(cx[k]), e.x);
      chk("CurrentY",   k, int'(cy[k]), e.y);
      chk("HBlank",     k, int'(hb[k]), e.hb);
      chk("VBlank",     k, int'(vb[k]), e.vb);
      chk("HSync",      k, int'(hs[k]), e.hs);
      chk("VSync",      k, int'(vs[k]), e.vs);
      chk("PixelTick",  k, int'(pt[k]), e.pt);
      chk("FrameStart", k, int'(fs[k]), e.fs);
    end
  end

  task automatic wait_n(int unsigned t);
    int unsigned guard = 0;
    while (n != t && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (n != t) begin
      checks++;
      errors++;
      $display("FAIL wait_n timeout: got n=%0d, expected n=%0d", n, t);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < NI; k++) begin
      chk("rst_cx", k, int'(cx[k]), 0);
      chk("rst_pt", k, int'(pt[k]), 0);
      chk("rst_hs", k, int'(hs[k]), 1);
      chk("rst_vs", k, int'(vs[k]), 1);
      chk("rst_fs", k, int'(fs[k]), 0);
    end

    wait_n(1);    chk("pt_div1", 2, int'(pt[2]), 1); chk("pt_div2_first", 0, int'(pt[0]), 0);
    wait_n(2);    chk("pt_div2", 0, int'(pt[0]), 1); chk("cx_div2", 0, int'(cx[0]), 1);
    wait_n(17);   chk("hs_pre",  2, int'(hs[2]), 1); chk("cx17", 2, int'(cx[2]), 17);
    wait_n(18);   chk("hs_fall", 2, int'(hs[2]), 0);
    wait_n(21);   chk("hs_last", 2, int'(hs[2]), 0);
    wait_n(22);   chk("hs_rise", 2, int'(hs[2]), 1);
    wait_n(25);   chk("line_wrap_x", 2, int'(cx[2]), 0); chk("line_wrap_y", 2, int'(cy[2]), 1);
    wait_n(501);  chk("vs_pre",  1, int'(vs[1]), 1);
    wait_n(502);  chk("vs_fall", 1, int'(vs[1]), 0);
    wait_n(601);  chk("vs_last", 1, int'(vs[1]), 0);
    wait_n(602);  chk("vs_rise", 1, int'(vs[1]), 1);
    wait_n(655);  chk("hs_pre_full",  3, int'(hs[3]), 1);
    wait_n(656);  chk("hs_fall_full", 3, int'(hs[3]), 0); chk("hb_full", 3, int'(hb[3]), 1);
    wait_n(748);  chk("vblank_tail", 1, int'(vb[1]), 1); chk("cy_clamp", 1, int'(cy[1]), 7);
    wait_n(750);
    chk("fs_first", 1, int'(fs[1]), 1); chk("fs_cx", 1, int'(cx[1]), 0);
    chk("fs_cy", 1, int'(cy[1]), 0);    chk("fs_vb", 1, int'(vb[1]), 0);
    chk("fs_hb", 1, int'(hb[1]), 0);
    wait_n(751);  chk("fs_one_cycle", 1, int'(fs[1]), 0); chk("hs_last_full", 3, int'(hs[3]), 0);
    wait_n(752);  chk("hs_rise_full", 3, int'(hs[3]), 1);
    wait_n(1278); chk("cx639", 0, int'(cx[0]), 639); chk("hb639", 0, int'(hb[0]), 0);
    wait_n(1280); chk("cx640", 0, int'(cx[0]), 640); chk("hb640", 0, int'(hb[0]), 1);
    wait_n(1313); chk("hsA_pre",  0, int'(hs[0]), 1);
    wait_n(1314); chk("hsA_fall", 0, int'(hs[0]), 0);
    wait_n(1500); chk("fs_second", 1, int'(fs[1]), 1);
    wait_n(1505); chk("hsA_last", 0, int'(hs[0]), 0);
    wait_n(1506); chk("hsA_rise", 0, int'(hs[0]), 1);
    wait_n(1598); chk("cx799", 0, int'(cx[0]), 799); chk("cy_line0", 0, int'(cy[0]), 0);
    wait_n(1600); chk("lineA_x", 0, int'(cx[0]), 0); chk("lineA_y", 0, int'(cy[0]), 1);

    // Asynchronous reset between edges, mid-frame for every instance.
    wait_n(4001);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("arst_cx", k, int'(cx[k]), 0); chk("arst_cy", k, int'(cy[k]), 0);
      chk("arst_hb", k, int'(hb[k]), 0); chk("arst_vb", k, int'(vb[k]), 0);
      chk("arst_hs", k, int'(hs[k]), 1); chk("arst_vs", k, int'(vs[k]), 1);
      chk("arst_pt", k, int'(pt[k]), 0); chk("arst_fs", k, int'(fs[k]), 0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;

    wait_n(1);    chk("restart_x", 0, int'(cx[0]), 0); chk("restart_pt", 0, int'(pt[0]), 0);
    wait_n(749);  chk("no_fs_early", 1, int'(fs[1]), 0);
    wait_n(750);  chk("fs_after_rst", 1, int'(fs[1]), 1);
    wait_n(1124); chk("no_fs_e", 4, int'(fs[4]), 0);
    wait_n(1125); chk("fs_e", 4, int'(fs[4]), 1);
    wait_n(2500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
